// File: rtl/block_serial_subtractor_pkg.sv
// Shared types and helpers for the block-serial subtractor: block width, FSM encoding
// and the block-index width function.
package sub_pkg;

   localparam int BLK_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of a counter able to index v blocks; never narrower than one bit.
   function automatic int clog2(input int v);
      int w;
      w = 1;
      while ((1 << w) < v) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/block_serial_subtractor_borrow_ripple_block.sv
// 4-bit combinational ripple-borrow subtractor: {bout, d} = a - b - bin.
// Zero latency, no flow control.
module borrow_ripple_block
   import sub_pkg::*;
(
   input  logic [BLK_W-1:0] a,
   input  logic [BLK_W-1:0] b,
   input  logic             bin,
   output logic [BLK_W-1:0] d,
   output logic             bout
);

   logic br;

   always_comb begin
      d  = '0;
      br = bin;
      for (int i = 0; i < BLK_W; i++) begin
         d[i] = a[i] ^ b[i] ^ br;
         br   = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br);
      end
      bout = br;
   end

endmodule

// File: rtl/block_serial_subtractor.sv
// Block-serial in1 - in2 - bin, one 4-bit block per clock; done pulses N/4 edges after an
// accepted start (earlier with EARLY_DONE_EN). start is ignored while busy; results hold until the next start.
module block_serial_subtractor
   import sub_pkg::*;
#(
   parameter int N = 32
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         bout,
   output logic         OF
);

   localparam int NBLK = N / BLK_W;
   localparam int KW   = clog2(NBLK);
   localparam logic [KW-1:0] LAST = KW'(NBLK - 1);

   if ((N % BLK_W) != 0 || N < 8) begin : g_bad_n
      $error("block_serial_subtractor: N must be a multiple of 4 and at least 8");
   end

   state_e         state_q, state_d;
   logic [KW-1:0]  k_q, k_d;
   logic           borrow_q, borrow_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [N-1:0]   diff_q, diff_d;
   logic           bout_q, bout_d;
   logic           of_q, of_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   int unsigned    blk_lo;
   logic [BLK_W-1:0] blk_a, blk_b, blk_d;
   logic           blk_bout;
   logic           finish;

   always_comb begin
      blk_lo = 32'(k_q) * BLK_W;
      blk_a  = a_q[blk_lo +: BLK_W];
      blk_b  = b_q[blk_lo +: BLK_W];
   end

   borrow_ripple_block u_blk (
      .a    (blk_a),
      .b    (blk_b),
      .bin  (borrow_q),
      .d    (blk_d),
      .bout (blk_bout)
   );

`ifdef EARLY_DONE_EN
   // Once the untouched upper bits of both operands match, every remaining block is
   // 0 - borrow, so the rest of diff is all-zeros or all-ones and the borrow passes straight out.
   logic         upper_eq;
   logic [N-1:0] fill_mask;

   always_comb begin
      upper_eq  = (((a_q ^ b_q) >> (blk_lo + BLK_W)) == '0);
      fill_mask = {N{1'b1}} << (blk_lo + BLK_W);
   end
`endif

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      of_d     = of_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      finish   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = in1;
               b_d      = in2;
               borrow_d = bin;
               k_d      = '0;
               diff_d   = '0;
               bout_d   = 1'b0;
               of_d     = 1'b0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end

         RUN: begin
            diff_d[blk_lo +: BLK_W] = blk_d;
            borrow_d = blk_bout;
            k_d      = k_q + 1'b1;
            finish   = (k_q == LAST);
`ifdef EARLY_DONE_EN
            if (!finish && upper_eq) begin
               if (blk_bout) begin
                  diff_d = diff_d | fill_mask;
               end
               finish = 1'b1;
            end
`endif
            if (finish) begin
               bout_d  = blk_bout;
               of_d    = (a_q[N-1] ^ b_q[N-1]) & (diff_d[N-1] ^ a_q[N-1]);
               done_d  = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         of_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         of_q     <= of_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign OF   = of_q;

endmodule

// File: doc/block_serial_subtractor.md
Name: block_serial_subtractor

Overview:
- Multi-cycle subtractor computing in1 - in2 - bin over N-bit operands, one 4-bit block per clock.
- Borrow-chain counterpart of the team's carry-increment adder. Shares its operand, cout/OF result conventions, with borrow replacing carry.
- Serves as the subtract stage for the sequential divider and multiplier datapaths, where area matters more than single-cycle latency.
- start/done handshake; results hold until the next accepted start.

Parameters:
- N, 32, operand width. Must be a multiple of 4 and >= 8; otherwise elaboration error.

Ports:
- clk    input   1   rising-edge clock
- rst    input   1   synchronous, active-high reset
- start  input   1   request; sampled only in IDLE
- in1    input   N   minuend; latched on accepted start
- in2    input   N   subtrahend; latched on accepted start
- bin    input   1   borrow-in; latched on accepted start
- busy   output  1   high in RUN and DONE
- done   output  1   one-cycle pulse when results are valid
- diff   output  N   in1 - in2 - bin, modulo 2^N
- bout   output  1   borrow-out; 1 iff unsigned in1 < in2 + bin
- OF     output  1   signed overflow: in1[N-1] != in2[N-1] and diff[N-1] != in1[N-1]

Behaviour:
- Reset (synchronous, active-high, clk domain):
  - Next edge forces IDLE; busy=0, done=0, diff=0, bout=0, OF=0.
  - Block index, borrow register and operand registers all clear.
  - Reset mid-RUN aborts the operation; no done pulse follows.
- IDLE, start=1 at edge 0:
  - Latch in1, in2 and bin into the borrow register.
  - Block index k=0; go to RUN.
- RUN, each edge:
  - Compute block k as {b_out, d} = a[4k+3:4k] - b[4k+3:4k] - borrow.
  - Write d into diff[4k+3:4k]; borrow <= b_out; k <= k+1.
- After block N/4-1 (edge N/4):
  - bout <= final borrow; OF updated; go to DONE.
- DONE:
  - done=1 for exactly one cycle (between edges N/4 and N/4+1), then IDLE.
  - Latency from accepted start to done high: N/4 edges. N=32 -> done high after edge 8.
- diff, bout, OF:
  - May update block-wise during RUN; valid only from done high.
  - Hold until the next accepted start clears diff to 0.
- start while busy: ignored; operands are not re-latched.
- start may be asserted in the same cycle that done is high; it is ignored. Earliest acceptance is the cycle after done.

Optional Feature:
- Macro: EARLY_DONE_EN.
- With the macro, after each RUN block k < N/4-1:
  - If the remaining upper bits of a and b are equal, all remaining diff blocks are 0x0 (borrow=0) or 0xF (borrow=1).
  - Fill them in the same edge; bout <= borrow; go to DONE next.
  - Latency becomes k+1 edges, at minimum 1.
- Without the macro: fixed N/4-edge latency. Results are identical in both builds.

Decomposition:
- Package sub_pkg:
  - BLK_W=4.
  - FSM state type: IDLE, RUN, DONE, 2-bit encoding.
  - Block-index width function clog2(N/4).
- Sub-module borrow_ripple_block:
  - 4-bit combinational ripple subtractor: a[3:0], b[3:0], bin -> d[3:0], bout.
  - Instantiated once; the FSM, registers and early-done compare stay in the top.

Test Plan:
- in1=0x00000005, in2=0x00000003, bin=0, start at edge 0 -> done high after edge 8 only; diff=0x00000002, bout=0, OF=0; busy low after edge 9.
- in1=0, in2=1, bin=0 -> diff=0xFFFFFFFF, bout=1, OF=0.
- in1=0x80000000, in2=0x00000001 -> diff=0x7FFFFFFF, bout=0, OF=1. Also in1=0x7FFFFFFF, in2=0xFFFFFFFF, bin=1 -> diff=0x7FFFFFFF, bout=1, OF=0.
- start held high with operands changed on edges 1..8 -> result matches edge-0 operands; exactly one done pulse per accepted start.
- rst=1 at edge 4 of RUN -> after edge 5: busy=0, done=0, diff=0, bout=0, OF=0; no done pulse. A fresh start then completes normally.
- EARLY_DONE_EN defined, in1=0x12340007, in2=0x12340009 -> done high after edge 1; diff=0xFFFFFFFE, bout=1, OF=0. Same stimulus without the macro: done after edge 8, identical results.
